note_tone_gen: RTL and testbench
================================

# note_tone_gen

Square-wave tone generator that sits downstream of the stage music sequencers and drives the buzzer pin. It samples `sound_en`/`note_sel`, converts the 4-bit note code to a half-period count, and toggles `speaker`. Note changes and stops take effect only on half-period boundaries, so no pulse is ever narrower than a half-period.

## Interface
- `CLK_HZ`, 12_000_000, system clock frequency in Hz; sets all half-period counts.
- `CNT_W`, 24, half-period counter width; must hold `CLK_HZ/524`.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sound_en`  in  1  1 = play `note_sel`, 0 = rest; driven by a stage music sequencer.
- `note_sel`  in  4  note code: 0..14 = C4 D4 E4 F4 G4 A4 B4 C5 D5 E5 F5 G5 A5 B5 C6; 15 = silence.
- `speaker`  out  1  square-wave output to the buzzer.
- `active`  out  1  1 while in TONE.
- `cur_note`  out  4  note code currently sounding; holds its last value in IDLE.

## Operation
- Note frequencies in Hz: 262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784, 880, 988, 1047.
- Half-period HALF(n) = floor(CLK_HZ / (2*f(n))), computed at elaboration. Clamp to a minimum of 2. Code 15 has no HALF.
- `play_req` = `sound_en` & (`note_sel` != 15).
- Reset: state IDLE, `speaker`=0, `active`=0, `cur_note`=0, counter=0, latched half=0.
- IDLE:
  - If `play_req`, then on the next edge: latch `cur_note`=`note_sel`, half=HALF(`note_sel`), `speaker`=1, counter=0, `active`=1, go to TONE.
  - Otherwise all outputs hold.
- TONE:
  - While counter != half-1: counter increments each cycle.
  - Boundary (counter == half-1), next edge: counter=0, and
    - `speaker`=1 and `play_req`=0: `speaker`=0, go to IDLE.
    - Otherwise: toggle `speaker`. If `play_req`, re-latch `cur_note` and half from the current `note_sel`. The new half governs the next half-period.
- Early stop:
  - In TONE with `speaker`=0 and `play_req`=0 on a non-boundary cycle: next edge goes to IDLE, counter=0, `active`=0, `speaker` stays 0.
  - A high half-period is always completed; a low one may be cut short.
- `note_sel` changes are ignored between boundaries. The value sampled on the boundary cycle wins.
- `sound_en` re-asserting while finishing a high half: the boundary toggles low and continues normally with no gap.
- Counter arithmetic is unsigned `CNT_W`; it never wraps, because it resets at half-1.

## Timing
- Start latency: `play_req` sampled at edge N gives `speaker`=1 and `active`=1 after edge N (registered, 1 cycle).
- Each `speaker` level lasts exactly half cycles; period = 2*half.
- Stop latency:
  - ≤ 1 cycle if `speaker` is low.
  - ≤ half cycles if high; `speaker` falls on the boundary edge and `active` falls on that same edge.
- Note change latency: ≤ half cycles, always aligned to a `speaker` edge.
- Reset wins over everything on the edge it is sampled, including mid-half-period.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Bench uses CLK_HZ=52_400, giving HALF(C4)=100, HALF(A4)=59, HALF(C6)=25.
- Start A4: reset, then `sound_en`=1, `note_sel`=5 held → `speaker` rises 1 cycle later, then toggles every 59 cycles (118-cycle period); `active`=1, `cur_note`=5.
- Mid-tone change: A4 playing, switch `note_sel`=0 at 20 cycles into a high half → the current half still lasts 59 cycles; halves of 100 follow; `cur_note`=0 at that boundary.
- Stop while high: C4 playing, drop `sound_en` 10 cycles into a high half → `speaker` stays high 90 more cycles, then 0; `active`=0 on the same edge; no further toggles.
- Stop while low: drop `sound_en` 10 cycles into a low half → next edge IDLE, `active`=0, `speaker`=0. Silence code: `sound_en`=1 with `note_sel`=15 from IDLE → stays IDLE, `speaker`=0.
- Reset mid-operation: assert `reset` one cycle mid-high on C6 → next edge `speaker`=0, `active`=0, `cur_note`=0. Release with `play_req` held → restart 1 cycle later with 25-cycle halves.
- Back-to-back sequencer pattern: `sound_en` toggled every 300 cycles with E4 (HALF 79) → every high pulse exactly 79 cycles, every tone starts high, no pulse < 79 high.

Source files
------------

// File: rtl/note_tone_gen.sv
// Square-wave buzzer tone generator: maps a 4-bit note code to a half-period
// count and toggles speaker, switching notes or stopping only on safe boundaries.
module note_tone_gen #(
    parameter int CLK_HZ = 12_000_000,
    parameter int CNT_W  = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sound_en,
    input  logic [3:0]       note_sel,
    output logic             speaker,
    output logic             active,
    output logic [3:0]       cur_note
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_TONE = 1'b1
    } state_t;

    // Half-period in clocks for a note code; code 15 (silence) maps to 0.
    function automatic logic [CNT_W-1:0] half_of(input int code);
        int f;
        int h;
        case (code)
            32'sd0:  f = 32'sd262;
            32'sd1:  f = 32'sd294;
            32'sd2:  f = 32'sd330;
            32'sd3:  f = 32'sd349;
            32'sd4:  f = 32'sd392;
            32'sd5:  f = 32'sd440;
            32'sd6:  f = 32'sd494;
            32'sd7:  f = 32'sd523;
            32'sd8:  f = 32'sd587;
            32'sd9:  f = 32'sd659;
            32'sd10: f = 32'sd698;
            32'sd11: f = 32'sd784;
            32'sd12: f = 32'sd880;
            32'sd13: f = 32'sd988;
            32'sd14: f = 32'sd1047;
            default: f = 32'sd0;
        endcase
        if (f == 32'sd0) begin
            h = 32'sd0;
        end else begin
            h = CLK_HZ / (32'sd2 * f);
            if (h < 32'sd2) begin
                h = 32'sd2;
            end else begin
                h = h;
            end
        end
        return CNT_W'(h);
    endfunction

    logic [CNT_W-1:0] half_tab_s [16];

    for (genvar g = 0; g < 16; g++) begin : g_half_tab
        assign half_tab_s[g] = half_of(g);
    end

    state_t           state_r,    state_s;
    logic [CNT_W-1:0] cnt_r,      cnt_s;
    logic [CNT_W-1:0] half_r,     half_s;
    logic             speaker_r,  speaker_s;
    logic             active_r,   active_s;
    logic [3:0]       cur_note_r, cur_note_s;
    logic             play_req_s;
    logic             boundary_s;

    assign play_req_s = sound_en & (note_sel != 4'd15);
    assign boundary_s = (cnt_r == (half_r - CNT_W'(1)));

    // Next-state and next-output logic for the IDLE/TONE controller.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        half_s     = half_r;
        speaker_s  = speaker_r;
        active_s   = active_r;
        cur_note_s = cur_note_r;
        case (state_r)
            S_IDLE: begin
                if (play_req_s) begin
                    state_s    = S_TONE;
                    cnt_s      = {CNT_W{1'b0}};
                    half_s     = half_tab_s[note_sel];
                    speaker_s  = 1'b1;
                    active_s   = 1'b1;
                    cur_note_s = note_sel;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_TONE: begin
                if (boundary_s) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (speaker_r && !play_req_s) begin
                        // A finished high half is the only place a high tone may stop.
                        speaker_s = 1'b0;
                        active_s  = 1'b0;
                        state_s   = S_IDLE;
                    end else begin
                        speaker_s = ~speaker_r;
                        if (play_req_s) begin
                            half_s     = half_tab_s[note_sel];
                            cur_note_s = note_sel;
                        end else begin
                            half_s = half_r;
                        end
                    end
                end else if (!speaker_r && !play_req_s) begin
                    // Low halves may be cut short without producing a narrow pulse.
                    state_s  = S_IDLE;
                    cnt_s    = {CNT_W{1'b0}};
                    active_s = 1'b0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s   = S_IDLE;
                cnt_s     = {CNT_W{1'b0}};
                speaker_s = 1'b0;
                active_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            half_r     <= {CNT_W{1'b0}};
            speaker_r  <= 1'b0;
            active_r   <= 1'b0;
            cur_note_r <= 4'd0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            half_r     <= half_s;
            speaker_r  <= speaker_s;
            active_r   <= active_s;
            cur_note_r <= cur_note_s;
        end
    end

    assign speaker  = speaker_r;
    assign active   = active_r;
    assign cur_note = cur_note_r;

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen at CLK_HZ=52_400 (C4=100, E4=79, A4=59, C6=25
// clocks per half-period).
module tb_note_tone_gen;

    logic       clk;
    logic       reset;
    logic       sound_en;
    logic [3:0] note_sel;
    logic       speaker;
    logic       active;
    logic [3:0] cur_note;

    int total;
    int bad;

    note_tone_gen #(
        .CLK_HZ (52_400),
        .CNT_W  (24)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sound_en (sound_en),
        .note_sel (note_sel),
        .speaker  (speaker),
        .active   (active),
        .cur_note (cur_note)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] sel;
        int         steps;
        logic       spk;
        logic       act;
        logic [3:0] note;
    } vec_t;

    vec_t tab [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act_v, input int exp_v);
        total++;
        if (act_v != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic check_out(input string name, input logic spk, input logic act,
                             input logic [3:0] note);
        check({name, ".speaker"}, int'(speaker), int'(spk));
        check({name, ".active"}, int'(active), int'(act));
        check({name, ".cur_note"}, int'(cur_note), int'(note));
    endtask

    // Count consecutive samples where speaker equals val, stepping after each.
    task automatic run_len(input logic val, input int limit, output int n);
        n = 0;
        while (speaker === val && n < limit) begin
            n++;
            step();
        end
    endtask

    initial begin
        int   n;
        int   hl;
        int   pulses;
        int   highs;
        logic prev;

        total = 0;
        bad   = 0;

        // en, sel, steps, speaker, active, cur_note
        tab[0] = '{1'b0, 4'd0,  1,  1'b0, 1'b0, 4'd0};
        tab[1] = '{1'b1, 4'd15, 3,  1'b0, 1'b0, 4'd0};
        tab[2] = '{1'b0, 4'd5,  2,  1'b0, 1'b0, 4'd0};
        tab[3] = '{1'b1, 4'd5,  1,  1'b1, 1'b1, 4'd5};
        tab[4] = '{1'b1, 4'd5,  58, 1'b1, 1'b1, 4'd5};
        tab[5] = '{1'b1, 4'd5,  1,  1'b0, 1'b1, 4'd5};
        tab[6] = '{1'b1, 4'd5,  58, 1'b0, 1'b1, 4'd5};
        tab[7] = '{1'b1, 4'd5,  1,  1'b1, 1'b1, 4'd5};
        tab[8] = '{1'b1, 4'd5,  59, 1'b0, 1'b1, 4'd5};

        reset    = 1'b1;
        sound_en = 1'b0;
        note_sel = 4'd0;
        step();
        step();
        check_out("reset", 1'b0, 1'b0, 4'd0);
        reset = 1'b0;

        // Table: idle, silence code, A4 start and first full period.
        for (int i = 0; i < 9; i++) begin
            sound_en = tab[i].en;
            note_sel = tab[i].sel;
            repeat (tab[i].steps) step();
            check_out($sformatf("vec%0d", i), tab[i].spk, tab[i].act, tab[i].note);
        end

        // Now at first low sample of A4.
        run_len(1'b0, 80, n);
        check("a4_low_len", n, 59);

        // Mid-tone change to C4, 20 cycles into a high half.
        repeat (20) step();
        note_sel = 4'd0;
        step();
        check("chg_mid_note", int'(cur_note), 5);
        run_len(1'b1, 80, n);
        check("chg_high_rest", n, 38);
        check("chg_new_note", int'(cur_note), 0);
        run_len(1'b0, 130, n);
        check("c4_low_len", n, 100);
        run_len(1'b1, 130, n);
        check("c4_high_len", n, 100);
        run_len(1'b0, 130, n);
        check("c4_low_len2", n, 100);

        // Stop while high: drop 10 cycles into the high half.
        repeat (10) step();
        sound_en = 1'b0;
        run_len(1'b1, 130, n);
        check("stop_high_len", n, 90);
        check_out("stop_high", 1'b0, 1'b0, 4'd0);
        highs = 0;
        repeat (150) begin
            step();
            if (speaker) highs++;
        end
        check("stop_no_toggle", highs, 0);

        // Stop while low on A4.
        sound_en = 1'b1;
        note_sel = 4'd5;
        step();
        check_out("a4_restart", 1'b1, 1'b1, 4'd5);
        run_len(1'b1, 80, n);
        check("a4_high_len", n, 59);
        repeat (10) step();
        sound_en = 1'b0;
        step();
        check_out("stop_low", 1'b0, 1'b0, 4'd5);

        // Reset mid-high on C6, then restart with play_req held.
        sound_en = 1'b1;
        note_sel = 4'd14;
        step();
        repeat (10) step();
        check_out("c6_mid", 1'b1, 1'b1, 4'd14);
        reset = 1'b1;
        step();
        check_out("c6_reset", 1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        step();
        check_out("c6_restart", 1'b1, 1'b1, 4'd14);
        run_len(1'b1, 40, n);
        check("c6_high_len", n, 25);
        run_len(1'b0, 40, n);
        check("c6_low_len", n, 25);
        sound_en = 1'b0;
        repeat (40) step();
        check_out("c6_stop", 1'b0, 1'b0, 4'd14);

        // Sequencer pattern: E4 bursts of 300 on / 300 off.
        note_sel = 4'd2;
        pulses   = 0;
        hl       = 0;
        prev     = speaker;
        for (int b = 0; b < 3; b++) begin
            for (int ph = 0; ph < 2; ph++) begin
                sound_en = (ph == 0);
                for (int s = 1; s <= 300; s++) begin
                    step();
                    if (ph == 0 && s == 1) check("burst_start", int'(speaker), 1);
                    if (speaker) begin
                        hl++;
                    end else if (prev) begin
                        check("burst_pulse", hl, 79);
                        pulses++;
                        hl = 0;
                    end
                    prev = speaker;
                end
            end
        end
        check("burst_pulses", pulses, 6);
        check_out("burst_end", 1'b0, 1'b0, 4'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
